// File: rtl/exe_mdu_ctrl.sv
// exe_mdu_ctrl -- EXE-stage multiply/divide unit controller with HI/LO registers.
//
// Runs MULT/MULTU/DIV/DIVU as ITER single-step iterations on operand
// magnitudes (shift-add multiply, restoring divide), then applies the sign
// fixup and writes HI/LO. The EXE stage stalls while an operation is in
// flight; the result is held in DONE until the downstream stage accepts it.
//
// Optional feature: define MDU_FAST_MUL_EN to compute MULT/MULTU in a single
// cycle (IDLE -> DONE directly). Divide always uses the iterative path.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   mdu_start            EXE holds a valid MDU instruction (level)
//   mdu_op[1:0]          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b         rs (multiplicand/dividend), rt (multiplier/divisor)
//   out_allow            downstream stage accepts the instruction
//   flush                cancel in-flight operation
//   hi_we, lo_we         MTHI/MTLO write strobes, data on hilo_wdata
//   ex_ready_go          EXE stage may forward its instruction
//   busy                 operation in CALC or DONE
//   hi, lo               architectural HI/LO registers
module exe_mdu_ctrl #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mdu_start,
  input  logic [1:0]      mdu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            out_allow,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] hilo_wdata,
  output logic            ex_ready_go,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                is_div;
  logic                neg_q;    // product / quotient sign
  logic                neg_r;    // remainder sign (follows dividend)
  logic [XLEN-1:0]     opnd;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc;      // mul: {partial, multiplier}; div: {rem, quo}

  // ---- start decode ----
  logic            op_signed, op_div, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    op_signed = ~mdu_op[0];
    op_div    = mdu_op[1];
    a_neg     = op_signed & src_a[XLEN-1];
    b_neg     = op_signed & src_b[XLEN-1];
    a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
    b_mag     = b_neg ? (~src_b + 1'b1) : src_b;
  end

  // ---- one iteration step ----
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     shifted;
  logic              take;
  logic [XLEN-1:0]   diff;
  logic [2*XLEN-1:0] step_next;

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
    shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    take    = shifted >= {1'b0, opnd};
    // remainder stays below the divisor, so the low XLEN bits are exact
    diff    = shifted[XLEN-1:0] - opnd;
    if (is_div)
      step_next = take ? {diff, acc[XLEN-2:0], 1'b1}
                       : {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      step_next = {mul_sum, acc[XLEN-1:1]};
  end

  // ---- sign fixup of the final step ----
  // Divide by zero needs no special case: every trial subtract succeeds,
  // giving an all-ones quotient and the dividend as remainder.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   hi_res, lo_res;

  always_comb begin
    prod_fix = neg_q ? (~step_next + 1'b1) : step_next;
    if (is_div) begin
      lo_res = neg_q ? (~step_next[XLEN-1:0] + 1'b1)      : step_next[XLEN-1:0];
      hi_res = neg_r ? (~step_next[2*XLEN-1:XLEN] + 1'b1) : step_next[2*XLEN-1:XLEN];
    end else begin
      lo_res = prod_fix[XLEN-1:0];
      hi_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag, fast_prod;

  always_comb begin
    fast_mag  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    fast_prod = (a_neg ^ b_neg) ? (~fast_mag + 1'b1) : fast_mag;
  end
`endif

  // ---- state machine ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= hilo_wdata;
          if (lo_we) lo <= hilo_wdata;
          if (mdu_start && !flush) begin
            cnt    <= '0;
            is_div <= op_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            opnd   <= op_div ? b_mag : a_mag;
            acc    <= {{XLEN{1'b0}}, (op_div ? a_mag : b_mag)};
`ifdef MDU_FAST_MUL_EN
            if (!op_div) begin
              hi    <= fast_prod[2*XLEN-1:XLEN];
              lo    <= fast_prod[XLEN-1:0];
              state <= S_DONE;
            end else begin
              state <= S_CALC;
            end
`else
            state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            acc <= step_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(ITER-1)) begin
              state <= S_DONE;
              hi    <= hi_res;
              lo    <= lo_res;
            end
          end
        end
        S_DONE: begin
          if (flush || out_allow) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign ex_ready_go = (state == S_DONE) | ~mdu_start;

endmodule
